// File: rtl/mod_div_32bit_pkg.sv
// Shared definitions for the sequential unsigned divider.
//   state_e     : FSM state encodings (IDLE/RUN/DONE; 2'd3 is illegal)
//   DEF_WIDTH   : default operand/result width
//   CNT_W       : iteration counter width (32 iterations)
package mod_div_32bit_pkg;

  localparam int unsigned DEF_WIDTH = 32;
  localparam int unsigned CNT_W     = 5;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/mod_div_32bit_sub_33bit.sv
// Combinational ripple subtractor: diff = x - y, built from full-adder slices
// on ~y with carry-in 1.
//   x, y : minuend / subtrahend (W bits)
//   diff : difference modulo 2^W
//   neg  : sign bit of the difference (diff[W-1])
module sub_33bit
  import mod_div_32bit_pkg::*;
#(
  parameter int unsigned W = DEF_WIDTH + 1
) (
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  output logic [W-1:0] diff,
  output logic         neg
);

  logic [W-1:0] y_inv;
  logic [W-1:0] carry;

  assign y_inv    = ~y;
  assign carry[0] = 1'b1;

  for (genvar i = 0; i < W; i++) begin : g_fa
    assign diff[i] = x[i] ^ y_inv[i] ^ carry[i];
    // The carry out of the top slice is not needed.
    if (i < W - 1) begin : g_carry
      assign carry[i+1] = (x[i] & y_inv[i]) | (carry[i] & (x[i] ^ y_inv[i]));
    end
  end

  assign neg = diff[W-1];

endmodule

// File: rtl/mod_div_32bit.sv
// Sequential unsigned divider, restoring algorithm, one quotient bit per clock.
//   clk         : system clock, rising edge
//   reset_n     : synchronous active-low reset
//   start       : request, sampled only in IDLE
//   a, b        : dividend / divisor, latched on the accepting edge
//   busy        : high in RUN and DONE
//   done        : one-cycle pulse, results valid
//   div_by_zero : set with done when b was 0
//   quotient    : a / b   (all ones on divide by zero)
//   remainder   : a mod b (a on divide by zero)
// All outputs are registered; results hold until the next completed operation.
module mod_div_32bit
  import mod_div_32bit_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  localparam logic [CNT_W-1:0] LastCnt = CNT_W'(WIDTH - 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  // Partial remainder. The algorithm's 33-bit R never has its top bit set
  // after an update (R < D), so only WIDTH bits are stored.
  logic [WIDTH-1:0]   r_q, r_d;
  logic [WIDTH-1:0]   q_q, q_d;
  logic [WIDTH-1:0]   d_q, d_d;
  logic [WIDTH-1:0]   quot_q, quot_d;
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic               dbz_q, dbz_d;
  logic               busy_q, done_q;

  logic [WIDTH:0]     r_shift;
  logic [WIDTH:0]     trial;
  logic               trial_neg;
  logic [WIDTH-1:0]   r_step;
  logic [WIDTH-1:0]   q_step;

  // {R,Q} << 1: the dividend MSB enters the remainder.
  assign r_shift = {r_q, q_q[WIDTH-1]};

  sub_33bit #(
    .W (WIDTH + 1)
  ) u_sub (
    .x    (r_shift),
    .y    ({1'b0, d_q}),
    .diff (trial),
    .neg  (trial_neg)
  );

  // Restore on a negative trial, otherwise keep the difference.
  assign r_step = trial_neg ? r_shift[WIDTH-1:0] : trial[WIDTH-1:0];
  assign q_step = {q_q[WIDTH-2:0], ~trial_neg};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    r_d     = r_q;
    q_d     = q_q;
    d_d     = d_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (b != '0) begin
            d_d     = b;
            q_d     = a;
            r_d     = '0;
            cnt_d   = '0;
            dbz_d   = 1'b0;
            state_d = S_RUN;
          end else begin
            quot_d  = '1;
            rem_d   = a;
            dbz_d   = 1'b1;
            state_d = S_DONE;
          end
        end
      end
      S_RUN: begin
        r_d   = r_step;
        q_d   = q_step;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LastCnt) begin
          // Load the results on the final iteration so they are stable in DONE.
          quot_d  = q_step;
          rem_d   = r_step;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      r_q     <= '0;
      q_q     <= '0;
      d_q     <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      r_q     <= r_d;
      q_q     <= q_d;
      d_q     <= d_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
      busy_q  <= (state_d != S_IDLE);
      done_q  <= (state_d == S_DONE);
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign div_by_zero = dbz_q;
  assign quotient    = quot_q;
  assign remainder   = rem_q;

endmodule
